// File: rtl/wide_add_pkg.sv
// Shared types, defaults and sizing helpers for the wide add/subtract sequencer.
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int N_DEF        = 16;
    localparam int WORDS_DEF    = 4;
    localparam int SKIP_BLK_DEF = 4;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Slice counter width: never narrower than one bit, even for a single slice.
    function automatic int cnt_width(input int words);
        return (clog2(words) < 1) ? 1 : clog2(words);
    endfunction

endpackage

// File: rtl/wide_add_sequencer_csa_slice.sv
// Combinational N-bit carry-skip adder: ripple inside each SKIP_BLK group,
// and a group whose bits all propagate passes its carry-in straight through.
module csa_slice #(
    parameter int N        = 16,
    parameter int SKIP_BLK = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int NBLK = N / SKIP_BLK;

    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        logic [SKIP_BLK-1:0] a_blk;
        logic [SKIP_BLK-1:0] b_blk;
        logic [SKIP_BLK-1:0] s_blk;
        logic                c_in;
        logic                c_ripple;
        logic                prop;
        logic                c_out;

        assign a_blk = a[g*SKIP_BLK +: SKIP_BLK];
        assign b_blk = b[g*SKIP_BLK +: SKIP_BLK];

        if (g == 0) begin : g_first
            assign c_in = cin;
        end else begin : g_rest
            assign c_in = g_blk[g-1].c_out;
        end

        // Ripple-carry add within the group.
        always_comb begin
            logic c;
            // NOTE: blocking assignments so each bit sees the carry just computed for the bit below it.
            c = c_in;
            for (int i = 0; i < SKIP_BLK; i++) begin
                s_blk[i] = a_blk[i] ^ b_blk[i] ^ c;
                c        = (a_blk[i] & b_blk[i]) | (c & (a_blk[i] ^ b_blk[i]));
            end
            c_ripple = c;
        end

        assign prop  = &(a_blk ^ b_blk);
        assign c_out = prop ? c_in : c_ripple;
        assign sum[g*SKIP_BLK +: SKIP_BLK] = s_blk;
    end

    assign cout = g_blk[NBLK-1].c_out;

endmodule

// File: rtl/wide_add_sequencer.sv
// W-bit add/subtract computed one N-bit slice per cycle, LSB first, through a
// single shared carry-skip slice adder, with valid/ready on both sides.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int WORDS    = WORDS_DEF,
    parameter int SKIP_BLK = SKIP_BLK_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic              cin,
    input  logic              sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*WORDS-1:0] sum,
    output logic              cout,
    output logic              ovf
);

    localparam int W  = N * WORDS;
    localparam int CW = cnt_width(WORDS);

    state_e        state_q, state_d;
    logic [CW-1:0] k_q, k_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic [N-1:0]  slice_a;
    logic [N-1:0]  slice_b;
    logic [N-1:0]  slice_sum;
    logic          slice_cout;
    logic          last_slice;

    assign slice_a    = a_q[int'(k_q)*N +: N];
    assign slice_b    = b_q[int'(k_q)*N +: N];
    assign last_slice = (k_q == CW'(WORDS - 1));

    csa_slice #(
        .N        (N),
        .SKIP_BLK (SKIP_BLK)
    ) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Next-state: operand capture, per-slice accumulate, result hand-off.
    always_comb begin
        // NOTE: every target gets a hold default first, so no branch can leave a latch behind.
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(k_q)*N +: N] = slice_sum;
                carry_d                 = slice_cout;
                if (last_slice) begin
                    cout_d  = slice_cout;
                    ovf_d   = (slice_a[N-1] == slice_b[N-1]) && (slice_sum[N-1] != slice_a[N-1]);
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, carry, operand and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the wide operand and result registers are reset too, so an aborted operation leaves nothing behind.
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench: directed corner cases with literal expectations, then
// randomized back-to-back traffic checked against an arithmetic reference model.
module tb_wide_add_sequencer;

    localparam int N        = 16;
    localparam int WORDS    = 4;
    localparam int SKIP_BLK = 4;
    localparam int W        = N * WORDS;

    localparam logic signed [W+1:0] SMAX = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] SMIN = {3'b111, {(W-1){1'b0}}};

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc_edge;
    } exp_t;

    exp_t exp_q[$];
    logic prev_valid = 1'b0;
    bit   b2b        = 1'b0;
    int   b2b_acc    = 0;
    int   last_acc   = 0;

    wide_add_sequencer #(
        .N        (N),
        .WORDS    (WORDS),
        .SKIP_BLK (SKIP_BLK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain unsigned and signed arithmetic on the full-width operands.
    function automatic exp_t model(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                                   input logic cin_v, input logic sub_v);
        exp_t e;
        logic [W:0] u;
        logic signed [W+1:0] s;
        if (sub_v) begin
            u      = {1'b0, a_v} - {1'b0, b_v};
            e.cout = (a_v >= b_v);
            s      = $signed({{2{a_v[W-1]}}, a_v}) - $signed({{2{b_v[W-1]}}, b_v});
        end else begin
            u      = {1'b0, a_v} + {1'b0, b_v} + {{W{1'b0}}, cin_v};
            e.cout = u[W];
            s      = $signed({{2{a_v[W-1]}}, a_v}) + $signed({{2{b_v[W-1]}}, b_v})
                   + $signed({{(W+1){1'b0}}, cin_v});
        end
        e.sum      = u[W-1:0];
        e.ovf      = (s > SMAX) || (s < SMIN);
        e.acc_edge = 0;
        return e;
    endfunction

    // Compare process: scoreboard of accepted operations vs. presented results.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                check("in_ready_in_done", in_ready, 0);
                if (exp_q.size() == 0) begin
                    check("spurious_result", out_valid, 0);
                end else begin
                    check("model_sum", sum, exp_q[0].sum);
                    check("model_cout", cout, exp_q[0].cout);
                    check("model_ovf", ovf, exp_q[0].ovf);
                    if (!prev_valid) begin
                        check("latency", cyc - exp_q[0].acc_edge, WORDS);
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                e          = model(a, b, cin, sub);
                e.acc_edge = cyc + 1;
                exp_q.push_back(e);
                if (b2b && b2b_acc > 0) begin
                    check("accept_spacing", e.acc_edge - last_acc, WORDS + 2);
                end
                last_acc = e.acc_edge;
                if (b2b) b2b_acc++;
            end
            prev_valid = out_valid;
        end
    end

    task automatic do_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                         input logic cin_v, input logic sub_v);
        bit ok;
        @(posedge clk);
        #1;
        a = a_v; b = b_v; cin = cin_v; sub = sub_v;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_timeout", ok, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("result_timeout", ok, 1);
    endtask

    task automatic consume();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic lit(input string name, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                       input logic cin_v, input logic sub_v,
                       input logic [W-1:0] e_sum, input logic e_cout, input logic e_ovf);
        out_ready = 1'b0;
        do_op(a_v, b_v, cin_v, sub_v);
        @(negedge clk);
        wait_valid();
        check({name, ".sum"}, sum, e_sum);
        check({name, ".cout"}, cout, e_cout);
        check({name, ".ovf"}, ovf, e_ovf);
        consume();
    endtask

    initial begin
        exp_t e;
        bit   ok;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #3;
        check("reset.in_ready", in_ready, 1);
        check("reset.out_valid", out_valid, 0);
        check("reset.sum", sum, 0);
        check("reset.cout", cout, 0);
        check("reset.ovf", ovf, 0);
        #19;
        rst_n = 1'b1;

        lit("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
        lit("borrow", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        lit("noborrow", 64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0);
        lit("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
            64'h8000_0000_0000_0000, 1'b0, 1'b1);
        lit("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
            64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        lit("cin_add", 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0000, 1'b1, 1'b0,
            64'h0000_0000_0001_0000, 1'b0, 1'b0);

        // Backpressure: result must hold while new operands are offered.
        e = model(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
        out_ready = 1'b0;
        do_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
        @(negedge clk);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = (i % 2 == 0);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            sub = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("bp.out_valid", out_valid, 1);
            check("bp.in_ready", in_ready, 0);
            check("bp.sum", sum, e.sum);
            check("bp.cout", cout, e.cout);
            check("bp.ovf", ovf, e.ovf);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp.release_valid", out_valid, 0);
        check("bp.release_ready", in_ready, 1);
        out_ready = 1'b0;

        // Asynchronous reset between slice 1 and slice 2.
        out_ready = 1'b1;
        do_op(64'hDEAD_BEEF_CAFE_F00D, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort.out_valid", out_valid, 0);
        check("abort.sum", sum, 0);
        check("abort.in_ready", in_ready, 1);
        check("abort.cout", cout, 0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b0;
        lit("after_abort", 64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0);

        // Back-to-back random traffic with both handshakes held high.
        b2b       = 1'b1;
        b2b_acc   = 0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            a   = {$urandom, $urandom};
            b   = ($urandom_range(0, 7) == 0) ? a : {$urandom, $urandom};
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (b2b_acc >= 200) break;
        end
        in_valid = 1'b0;
        b2b      = 1'b0;
        check("b2b.accepts", (b2b_acc >= 200), 1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("b2b.drained", ok, 1);
        @(negedge clk);
        check("idle.in_ready", in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
Multi-cycle controller that performs W-bit add/subtract by streaming N-bit slices, LSB first, through one shared combinational N-bit carry-skip adder. The inter-slice carry is registered between cycles. Valid/ready handshakes are used on both the operand side and the result side. The block lets narrow carry-skip hardware serve wide operands, for example 64-bit operands on a 16-bit adder.

Parameters:
- N, 16, slice width = adder width; must be ≥ 2.
- WORDS, 4, number of slices; must be ≥ 1.
- SKIP_BLK, 4, carry-skip block size passed to the slice adder; N must be divisible by SKIP_BLK.
- W (localparam), N*WORDS, full operand width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset; applies to all flops.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0 = A+B+cin, 1 = A−B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- sum  output  W  result.
- cout  output  1  final carry-out; for subtract, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (async assert, any state): state=IDLE, slice counter=0, carry reg=0, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0; operand registers=0.
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture A, capture B_eff = sub ? ~b : b, set carry = sub ? 1 : cin, set k=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle the adder receives A[k*N +: N], B_eff[k*N +: N] and carry.
  - At the clock edge: sum[k*N +: N] takes the adder sum, carry takes the adder cout, k increments.
  - When k==WORDS-1 at the edge, load cout and ovf, and go to DONE.
- Overflow rule: ovf = (A[W-1]==B_eff[W-1]) && (slice sum MSB != A[W-1]), evaluated on the last slice.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable.
  - On out_ready: go to IDLE; out_valid drops the next cycle.
- Latency: accept at edge E0 → out_valid high after edge E_WORDS.
- Throughput: one operation per WORDS+2 cycles when out_ready is held high. There is no overlap of consecutive operations.
- in_valid during RUN or DONE is ignored; operands are not re-sampled.
- out_ready during IDLE or RUN has no effect.
- sum holds the previous result until the next operation overwrites it slice by slice. Partial sum is visible during RUN but out_valid is 0.
- WORDS=1: a single RUN cycle, then DONE.
- Reset mid-RUN or mid-DONE: the operation is aborted, all outputs return to reset values, and no result is produced.
- Arithmetic is modulo 2^W. Subtract is A + ~B + 1.

Decomposition:
- Package wide_add_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Default N / WORDS / SKIP_BLK constants.
  - Helper function clog2 for sizing the slice counter (max(1, clog2(WORDS)) bits).
- Sub-module csa_slice: the combinational N-bit carry-skip adder (ports a, b, cin, sum, cout; parameters N, SKIP_BLK). It is instantiated once and contains no state.
- The sequencer holds the FSM, the counter, the carry register, the operand registers and the result registers.

Test Plan:
- Add with ripple across all slices, N=16, WORDS=4: a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0 → sum=0, cout=1, ovf=0. out_valid rises exactly 4 cycles after the accept edge.
- Subtract with borrow: a=5, b=7, sub=1 → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. A second case a=7, b=5 → sum=2, cout=1.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, add → sum=0x8000_0000_0000_0000, ovf=1, cout=0. A second case a=0x8000_0000_0000_0000, b=1, sub=1 → ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE, with in_valid pulsed and new a/b applied → out_valid stays 1, sum/cout/ovf are unchanged, in_ready=0, and the new operands are not captured. Raising out_ready leads to IDLE next cycle.
- Async reset mid-RUN: assert rst_n=0 between slice 1 and slice 2 → out_valid=0, sum=0, in_ready=1 immediately. After release, a fresh add of 3+4 completes correctly with sum=7.
- Back-to-back with in_valid and out_ready held high and random a/b/sub/cin over 200 ops → results match the reference model (A ± B) mod 2^64. Accepts are spaced exactly WORDS+2 = 6 cycles apart.
